period_meter: RTL and testbench



---
 rtl/period_meter_pkg.sv | 13 +
 rtl/period_meter_rising_edge.sv | 24 ++
 rtl/period_meter.sv | 115 +++++++++++
 tb/tb_period_meter.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/period_meter_pkg.sv
// Shared constants for the period meter: state encoding and default counter width.
// Monitors and benches import this package so they decode the state identically.
package period_meter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        MEASURE = 2'd2
    } state_e;

    localparam int unsigned DEFAULT_BIT_FIELD = 8;

endpackage

// File: rtl/period_meter_rising_edge.sv
// Rising-edge detector for a CLK-synchronous tick stream, sampled on the falling
// CLK edge. The delayed copy of the tick keeps tracking regardless of any
// consumer state, so an edge is never lost across an enable change.
module period_meter_rising_edge (
    input  logic clk_i,
    input  logic clear_ni,
    input  logic tick_i,
    output logic edge_o
);

    logic tick_q;

    // Delay the tick by one falling edge so a low-to-high transition is visible.
    always_ff @(negedge clk_i or negedge clear_ni) begin
        if (!clear_ni) begin
            tick_q <= 1'b0;
        end else begin
            tick_q <= tick_i;
        end
    end

    assign edge_o = tick_i & ~tick_q;

endmodule

// File: rtl/period_meter.sv
// Period meter: counts CLK cycles between successive rising edges of TICK,
// strobes VALID with the new Period, raises LOCK when two consecutive periods
// match and sets a sticky OVERFLOW when the counter range is exhausted.
module period_meter
    import period_meter_pkg::*;
#(
    parameter int unsigned bitField = DEFAULT_BIT_FIELD
) (
    input  logic                CLK,
    input  logic                CLEAR,
    input  logic                TICK,
    input  logic                ENABLE,
    output logic [bitField-1:0] Period,
    output logic                VALID,
    output logic                LOCK,
    output logic                OVERFLOW
);

    localparam logic [bitField-1:0] CNT_ZERO = {bitField{1'b0}};
    localparam logic [bitField-1:0] CNT_ONE  = {{(bitField-1){1'b0}}, 1'b1};
    localparam logic [bitField-1:0] CNT_MAX  = {bitField{1'b1}};

    state_e              state_q, state_d;
    logic [bitField-1:0] count_q, count_d;
    logic [bitField-1:0] period_q, period_d;
    logic                valid_q, valid_d;
    logic                lock_q, lock_d;
    logic                overflow_q, overflow_d;
    logic                edge_s;

    period_meter_rising_edge u_rising_edge (
        .clk_i    (CLK),
        .clear_ni (CLEAR),
        .tick_i   (TICK),
        .edge_o   (edge_s)
    );

    // Next-state logic: enable has priority, then the per-state measurement rules.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        period_d   = period_q;
        valid_d    = 1'b0;
        lock_d     = lock_q;
        overflow_d = overflow_q;
        if (!ENABLE) begin
            // Abort any measurement; Period and OVERFLOW keep their last values.
            state_d = IDLE;
            count_d = CNT_ZERO;
            lock_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = ARMED;
                    count_d = CNT_ZERO;
                end
                ARMED: begin
                    if (edge_s) begin
                        state_d = MEASURE;
                        count_d = CNT_ONE;
                    end else begin
                        count_d = CNT_ZERO;
                    end
                end
                MEASURE: begin
                    if (edge_s) begin
                        // An edge wins over a simultaneous all-ones count.
                        period_d   = count_q;
                        valid_d    = 1'b1;
                        lock_d     = (count_q == period_q);
                        overflow_d = 1'b0;
                        count_d    = CNT_ONE;
                    end else if (count_q == CNT_MAX) begin
                        // Timeout pre-empts the counter wrap; re-arm without a result.
                        overflow_d = 1'b1;
                        lock_d     = 1'b0;
                        state_d    = ARMED;
                        count_d    = CNT_ZERO;
                    end else begin
                        count_d = count_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    count_d = CNT_ZERO;
                end
            endcase
        end
    end

    // State and output registers, updated on the falling CLK edge.
    always_ff @(negedge CLK or negedge CLEAR) begin
        if (!CLEAR) begin
            state_q    <= IDLE;
            count_q    <= CNT_ZERO;
            period_q   <= CNT_ZERO;
            valid_q    <= 1'b0;
            lock_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            period_q   <= period_d;
            valid_q    <= valid_d;
            lock_q     <= lock_d;
            overflow_q <= overflow_d;
        end
    end

    assign Period   = period_q;
    assign VALID    = valid_q;
    assign LOCK     = lock_q;
    assign OVERFLOW = overflow_q;

endmodule

// File: tb/tb_period_meter.sv
// Bench for period_meter: two instances (8-bit and 4-bit counters) share one
// stimulus stream. A reference model driven by edge timestamps pushes expected
// results into per-instance queues; a monitor pops them on VALID.
module tb_period_meter;

    logic       CLK    = 1'b0;
    logic       CLEAR  = 1'b1;
    logic       TICK   = 1'b0;
    logic       ENABLE = 1'b0;

    logic [7:0] p8;
    logic       v8, l8, o8;
    logic [3:0] p4;
    logic       v4, l4, o4;

    period_meter #(.bitField(8)) u_dut8 (
        .CLK(CLK), .CLEAR(CLEAR), .TICK(TICK), .ENABLE(ENABLE),
        .Period(p8), .VALID(v8), .LOCK(l8), .OVERFLOW(o8)
    );

    period_meter #(.bitField(4)) u_dut4 (
        .CLK(CLK), .CLEAR(CLEAR), .TICK(TICK), .ENABLE(ENABLE),
        .Period(p4), .VALID(v4), .LOCK(l4), .OVERFLOW(o4)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;

    // Expected VALID results, encoded as period*2 + lock.
    int exp_q0[$];
    int exp_q1[$];

    // Reference model state, per instance (0: 8-bit, 1: 4-bit).
    int   mdl_active [2];
    int   mdl_has_ref[2];
    int   mdl_ref_cyc[2];
    int   mdl_period [2];
    int   mdl_lock   [2];
    int   mdl_ovf    [2];
    int   mdl_cyc    = 0;
    logic mdl_tick_prev = 1'b0;
    logic mdl_edge;

    function automatic int limit_of(input int i);
        return (i == 0) ? 255 : 15;
    endfunction

    task automatic check(input string name, input int got, input int want);
        n_checks++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, want, $time);
    endtask

    // One falling-edge step of the model, in terms of edge timestamps.
    task automatic model_step(input int i, input logic edge_now);
        int p;
        if (!ENABLE) begin
            mdl_active[i]  = 0;
            mdl_has_ref[i] = 0;
            mdl_lock[i]    = 0;
        end else if (mdl_active[i] == 0) begin
            mdl_active[i] = 1;
        end else if (edge_now) begin
            if (mdl_has_ref[i] != 0) begin
                p = mdl_cyc - mdl_ref_cyc[i];
                mdl_lock[i]   = (p == mdl_period[i]) ? 1 : 0;
                mdl_period[i] = p;
                mdl_ovf[i]    = 0;
                if (i == 0) exp_q0.push_back(p * 2 + mdl_lock[i]);
                else        exp_q1.push_back(p * 2 + mdl_lock[i]);
            end
            mdl_ref_cyc[i] = mdl_cyc;
            mdl_has_ref[i] = 1;
        end else if (mdl_has_ref[i] != 0 && (mdl_cyc - mdl_ref_cyc[i]) == limit_of(i)) begin
            mdl_ovf[i]     = 1;
            mdl_lock[i]    = 0;
            mdl_has_ref[i] = 0;
        end
    endtask

    // Model evaluation on the same events as the design.
    always @(negedge CLK or negedge CLEAR) begin
        if (!CLEAR) begin
            for (int i = 0; i < 2; i++) begin
                mdl_active[i]  = 0;
                mdl_has_ref[i] = 0;
                mdl_ref_cyc[i] = 0;
                mdl_period[i]  = 0;
                mdl_lock[i]    = 0;
                mdl_ovf[i]     = 0;
            end
            exp_q0.delete();
            exp_q1.delete();
            mdl_tick_prev = 1'b0;
        end else begin
            mdl_edge = TICK & ~mdl_tick_prev;
            mdl_cyc++;
            for (int i = 0; i < 2; i++) model_step(i, mdl_edge);
            mdl_tick_prev = TICK;
        end
    end

    task automatic monitor_one(input int i, input logic v, input int p, input logic l, input logic o);
        string tag;
        int    e;
        int    have;
        tag  = (i == 0) ? "u8" : "u4";
        have = (i == 0) ? exp_q0.size() : exp_q1.size();
        if (v) begin
            if (have > 0) begin
                e = (i == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                check({tag, "_valid_period"}, p, e / 2);
                check({tag, "_valid_lock"}, int'(l), e % 2);
            end else begin
                check({tag, "_unexpected_valid"}, int'(v), 0);
            end
        end else if (have > 0) begin
            e = (i == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            check({tag, "_missing_valid"}, int'(v), 1);
        end
        check({tag, "_period"}, p, mdl_period[i]);
        check({tag, "_lock"}, int'(l), mdl_lock[i]);
        check({tag, "_overflow"}, int'(o), mdl_ovf[i]);
    endtask

    // Monitor: sample outputs on the rising edge, half a cycle after updates.
    always @(posedge CLK) begin
        monitor_one(0, v8, int'(p8), l8, o8);
        monitor_one(1, v4, int'(p4), l4, o4);
    end

    task automatic cycle();
        @(posedge CLK);
        #1;
    endtask

    // One-cycle TICK pulse followed by low cycles; edge spacing is n.
    task automatic tick_gap(input int n);
        TICK = 1'b1;
        cycle();
        TICK = 1'b0;
        repeat (n - 1) cycle();
    endtask

    initial begin
        int r, gap, hi;
        #1 CLEAR = 1'b0;
        repeat (3) cycle();
        CLEAR = 1'b1;
        repeat (2) cycle();
        ENABLE = 1'b1;
        repeat (3) cycle();

        // Divider lock at 16.
        repeat (6) tick_gap(16);
        // Period change 10, 10, 12.
        tick_gap(10); tick_gap(10); tick_gap(12); tick_gap(10);
        // Overflow on the 4-bit instance, then recovery at period 5.
        tick_gap(40);
        tick_gap(5); tick_gap(5); tick_gap(5);
        // 4-bit boundary: 15 is measurable, 16 overflows.
        repeat (4) tick_gap(15);
        tick_gap(16); tick_gap(15); tick_gap(15);
        // 8-bit boundary: 255 is measurable, 256 overflows.
        tick_gap(255); tick_gap(255); tick_gap(256); tick_gap(16); tick_gap(16);

        // Enable drop mid-measurement.
        repeat (3) tick_gap(16);
        TICK = 1'b1; cycle(); TICK = 1'b0;
        repeat (7) cycle();
        ENABLE = 1'b0;
        repeat (4) cycle();
        ENABLE = 1'b1;
        repeat (2) cycle();
        repeat (4) tick_gap(16);

        // Edge coinciding with enable rise.
        ENABLE = 1'b0;
        repeat (3) cycle();
        ENABLE = 1'b1;
        repeat (3) tick_gap(9);

        // Asynchronous clear between falling edges mid-measurement.
        TICK = 1'b1; cycle(); TICK = 1'b0;
        repeat (5) cycle();
        #2 CLEAR = 1'b0;
        #1;
        check("async_u8_period", int'(p8), 0);
        check("async_u8_valid", int'(v8), 0);
        check("async_u8_lock", int'(l8), 0);
        check("async_u8_overflow", int'(o8), 0);
        check("async_u4_period", int'(p4), 0);
        check("async_u4_valid", int'(v4), 0);
        check("async_u4_lock", int'(l4), 0);
        check("async_u4_overflow", int'(o4), 0);
        CLEAR = 1'b1;
        repeat (3) tick_gap(12);

        // Randomized tick spacing, pulse width and enable drops.
        repeat (150) begin
            r = int'($urandom_range(0, 9));
            if (r == 0) begin
                ENABLE = 1'b0;
                repeat (int'($urandom_range(1, 4))) cycle();
                ENABLE = 1'b1;
            end
            gap = int'($urandom_range(2, 24));
            if (r == 1) gap = int'($urandom_range(250, 270));
            hi = int'($urandom_range(1, gap - 1));
            TICK = 1'b1;
            repeat (hi) cycle();
            TICK = 1'b0;
            repeat (gap - hi) cycle();
        end

        ENABLE = 1'b0;
        repeat (3) cycle();
        check("u8_queue_drained", exp_q0.size(), 0);
        check("u4_queue_drained", exp_q1.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
